// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, legal
// write-strobe patterns and the strobe/alignment legality rule.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] SEL_W  = 4'b1111;
   localparam logic [3:0] SEL_H0 = 4'b0011;
   localparam logic [3:0] SEL_H1 = 4'b1100;
   localparam logic [3:0] SEL_B0 = 4'b0001;
   localparam logic [3:0] SEL_B1 = 4'b0010;
   localparam logic [3:0] SEL_B2 = 4'b0100;
   localparam logic [3:0] SEL_B3 = 4'b1000;

   // Word stores must be word aligned, halfword stores halfword aligned.
   function automatic logic sel_legal(input logic [3:0] sel, input logic [1:0] lsb);
      case (sel)
         SEL_W:                          return (lsb == 2'b00);
         SEL_H0, SEL_H1:                 return !lsb[0];
         SEL_B0, SEL_B1, SEL_B2, SEL_B3: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised SRAM built from four byte banks with per-lane write enables
// and a registered read port that clears on reset.
module dmem_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] widx_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] ridx_i,
   output logic [31:0]   rdata_o
);

   for (genvar l = 0; l < 4; l++) begin : g_bank
      logic [7:0] bank_q [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (we_i[l]) bank_q[widx_i] <= wdata_i[8*l +: 8];
      end

      always_ff @(posedge clk) begin
         if (rst)       rd_q <= '0;
         else if (re_i) rd_q <= bank_q[ridx_i];
      end

      assign rdata_o[8*l +: 8] = rd_q;
   end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: accepts one access at a time, counts read
// wait states, raises stall while busy and flags misaligned/illegal stores.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH     = 1024,
   parameter int AW        = 10,
   parameter int LATENCY   = 2,
   parameter int WR_POSTED = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        we,
   input  logic [3:0]  sel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        addr_err
);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    lanes_q, lanes_d;
   logic          wr_q, wr_d;
   logic          addr_err_q, addr_err_d;
   logic          stall_c;

   logic [3:0]    arr_we;
   logic [AW-1:0] arr_widx, arr_ridx;
   logic [31:0]   arr_wdata;
   logic          arr_re;

   logic [AW-1:0] idx_in;
   logic [3:0]    lanes_in;
   logic          legal_in;
   logic          unused_addr_hi;

   // Upper address bits alias onto the array.
   assign idx_in         = addr[AW+1:2];
   assign unused_addr_hi = ^addr[31:AW+2];
   assign legal_in       = sel_legal(sel, addr[1:0]);
   assign lanes_in       = legal_in ? sel : 4'b0000;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      lanes_d    = lanes_q;
      wr_d       = wr_q;
      addr_err_d = 1'b0;
      stall_c    = 1'b0;
      arr_we     = 4'b0000;
      arr_widx   = idx_q;
      arr_wdata  = wdata_q;
      arr_re     = 1'b0;
      arr_ridx   = idx_q;

      case (state_q)
         IDLE: begin
            if (en) begin
               addr_err_d = we && !legal_in;
               if (we && (WR_POSTED != 0)) begin
                  arr_we    = lanes_in;
                  arr_widx  = idx_in;
                  arr_wdata = wdata;
               end else begin
                  stall_c = 1'b1;
                  idx_d   = idx_in;
                  wdata_d = wdata;
                  lanes_d = lanes_in;
                  wr_d    = we;
                  cnt_d   = 4'(LATENCY - 1);
                  if (LATENCY == 1) begin
                     state_d   = DONE;
                     arr_widx  = idx_in;
                     arr_wdata = wdata;
                     arr_ridx  = idx_in;
                     if (we) arr_we = lanes_in;
                     else    arr_re = 1'b1;
                  end else begin
                     state_d = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            stall_c = 1'b1;
            if (cnt_q == 4'd1) begin
               state_d = DONE;
               cnt_d   = 4'd0;
               if (wr_q) arr_we = lanes_q;
               else      arr_re = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         // The completing instruction is still in M, so en is not looked at.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_err_q <= addr_err_d;
      end
   end

   always_ff @(posedge clk) begin
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      lanes_q <= lanes_d;
      wr_q    <= wr_d;
   end

   // A reset edge must never commit a pending or posted write.
   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .we_i    (arr_we & {4{!rst}}),
      .widx_i  (arr_widx),
      .wdata_i (arr_wdata),
      .re_i    (arr_re & !rst),
      .ridx_i  (arr_ridx),
      .rdata_o (rdata)
   );

   assign stall    = stall_c && !rst;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: posted-write/LATENCY=2 instance and a
// non-posted/LATENCY=3 instance, checked against a word-map reference model.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, en_a, we_a, stall_a, err_a;
   logic [3:0]  sel_a;
   logic [31:0] addr_a, wdata_a, rdata_a;
   logic        rst_b, en_b, we_b, stall_b, err_b;
   logic [3:0]  sel_b;
   logic [31:0] addr_b, wdata_b, rdata_b;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl [int];

   dmem_responder #(.DEPTH(1024), .AW(10), .LATENCY(2), .WR_POSTED(1)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .we(we_a), .sel(sel_a), .addr(addr_a),
      .wdata(wdata_a), .rdata(rdata_a), .stall(stall_a), .addr_err(err_a)
   );

   dmem_responder #(.DEPTH(1024), .AW(10), .LATENCY(3), .WR_POSTED(0)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .we(we_b), .sel(sel_b), .addr(addr_b),
      .wdata(wdata_b), .rdata(rdata_b), .stall(stall_b), .addr_err(err_b)
   );

   // Reference rules: one-hot strobes anywhere, halves on even bytes, words aligned.
   function automatic bit legal_m(input logic [3:0] s, input logic [31:0] a);
      if ($countones(s) == 1) return 1'b1;
      if (s == 4'b0011 || s == 4'b1100) return (a[0] == 1'b0);
      if (s == 4'b1111) return (a[1:0] == 2'b00);
      return 1'b0;
   endfunction

   function automatic int mkey(input int dut, input logic [31:0] a);
      return dut * 2048 + int'((a >> 2) % 1024);
   endfunction

   function automatic logic [31:0] mread(input int dut, input logic [31:0] a);
      int k = mkey(dut, a);
      return mdl.exists(k) ? mdl[k] : 32'h0;
   endfunction

   task automatic mwrite(input int dut, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] w;
      if (!legal_m(s, a)) return;
      w = mread(dut, a);
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      mdl[mkey(dut, a)] = w;
   endtask

   // One CPU access held until stall drops, then one idle cycle.
   task automatic acc_a(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                        output int nst, output logic [31:0] rd, output int nerr, output logic [31:0] rd_end);
      en_a = 1'b1; we_a = w; sel_a = s; addr_a = a; wdata_a = d;
      nst = 0; nerr = 0; rd = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (err_a) nerr++;
         if (!stall_a) begin rd = rdata_a; break; end
         nst++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      en_a = 1'b0; we_a = 1'b0;
      @(negedge clk);
      if (err_a) nerr++;
      rd_end = rdata_a;
      @(posedge clk); #1;
   endtask

   task automatic acc_b(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                        output int nst, output logic [31:0] rd, output int nerr);
      en_b = 1'b1; we_b = w; sel_b = s; addr_b = a; wdata_b = d;
      nst = 0; nerr = 0; rd = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (err_b) nerr++;
         if (!stall_b) begin rd = rdata_b; break; end
         nst++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      en_b = 1'b0; we_b = 1'b0;
      @(negedge clk);
      if (err_b) nerr++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
      sel_a = 4'hF; sel_b = 4'hF; addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL rst_stall_a got=%b exp=0", stall_a); end
      checks++; if (stall_b !== 1'b0) begin failures++; $display("FAIL rst_stall_b got=%b exp=0", stall_b); end
      @(posedge clk); #1;
      rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
      @(negedge clk);
      checks++; if (rdata_a !== 32'h0) begin failures++; $display("FAIL rst_rdata_a got=%h exp=0", rdata_a); end
      checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL rst_err_a got=%b exp=0", err_a); end
      checks++; if (rdata_b !== 32'h0) begin failures++; $display("FAIL rst_rdata_b got=%h exp=0", rdata_b); end
      @(posedge clk); #1;
   endtask

   task automatic test_posted_rw();
      int nst, nerr; logic [31:0] rd, rde;
      acc_a(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, nst, rd, nerr, rde);
      mwrite(0, 4'b1111, 32'h10, 32'hDEADBEEF);
      checks++; if (nst !== 0) begin failures++; $display("FAIL posted_wr_stall got=%0d exp=0", nst); end
      acc_a(1'b0, 4'b0000, 32'h10, 32'h0, nst, rd, nerr, rde);
      checks++; if (nst !== 2) begin failures++; $display("FAIL rd_stall_cycles got=%0d exp=2", nst); end
      checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
      acc_a(1'b1, 4'b0100, 32'h10, 32'h00AA0000, nst, rd, nerr, rde);
      mwrite(0, 4'b0100, 32'h10, 32'h00AA0000);
      checks++; if (rde !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_keeps_rdata got=%h exp=deadbeef", rde); end
      acc_a(1'b0, 4'b0000, 32'h10, 32'h0, nst, rd, nerr, rde);
      checks++; if (rd !== 32'hDEAABEEF) begin failures++; $display("FAIL byte_merge got=%h exp=deaabeef", rd); end
   endtask

   task automatic test_illegal_write();
      int nst, nerr; logic [31:0] rd, rde;
      acc_a(1'b1, 4'b1111, 32'h20, 32'hA5A5A5A5, nst, rd, nerr, rde);
      mwrite(0, 4'b1111, 32'h20, 32'hA5A5A5A5);
      checks++; if (nerr !== 0) begin failures++; $display("FAIL legal_wr_err got=%0d exp=0", nerr); end
      acc_a(1'b1, 4'b0101, 32'h20, 32'h11111111, nst, rd, nerr, rde);
      checks++; if (nerr !== 1) begin failures++; $display("FAIL ill_sel_err got=%0d exp=1", nerr); end
      acc_a(1'b1, 4'b1111, 32'h22, 32'h22222222, nst, rd, nerr, rde);
      checks++; if (nerr !== 1) begin failures++; $display("FAIL ill_align_err got=%0d exp=1", nerr); end
      acc_a(1'b1, 4'b0000, 32'h20, 32'h33333333, nst, rd, nerr, rde);
      checks++; if (nerr !== 1) begin failures++; $display("FAIL ill_zero_err got=%0d exp=1", nerr); end
      acc_a(1'b0, 4'b0101, 32'h22, 32'h0, nst, rd, nerr, rde);
      checks++; if (nerr !== 0) begin failures++; $display("FAIL rd_no_err got=%0d exp=0", nerr); end
      checks++; if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL ill_unchanged got=%h exp=a5a5a5a5", rd); end
   endtask

   task automatic test_back_to_back();
      logic exp_st [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      int nst, nerr; logic [31:0] rd, rde;
      acc_a(1'b1, 4'b1111, 32'h14, 32'h0BADF00D, nst, rd, nerr, rde);
      mwrite(0, 4'b1111, 32'h14, 32'h0BADF00D);
      en_a = 1'b1; we_a = 1'b0; sel_a = 4'h0;
      for (int c = 0; c < 6; c++) begin
         addr_a = (c < 3) ? 32'h10 : 32'h14;
         @(negedge clk);
         checks++; if (stall_a !== exp_st[c]) begin failures++; $display("FAIL b2b_stall c=%0d got=%b exp=%b", c, stall_a, exp_st[c]); end
         if (c == 2 || c == 5) begin
            rd = mread(0, addr_a);
            checks++; if (rdata_a !== rd) begin failures++; $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, rdata_a, rd); end
         end
         @(posedge clk); #1;
      end
      en_a = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      int nst, nerr; logic [31:0] rd, rde;
      acc_a(1'b1, 4'b1111, 32'h0, 32'h11223344, nst, rd, nerr, rde);
      acc_a(1'b1, 4'b0001, 32'h1000, 32'h00000055, nst, rd, nerr, rde);
      mwrite(0, 4'b1111, 32'h0, 32'h11223344);
      mwrite(0, 4'b0001, 32'h1000, 32'h00000055);
      acc_a(1'b0, 4'b0000, 32'h0, 32'h0, nst, rd, nerr, rde);
      checks++; if (rd[7:0] !== 8'h55) begin failures++; $display("FAIL wrap_byte got=%h exp=55", rd[7:0]); end
      checks++; if (rd !== 32'h11223355) begin failures++; $display("FAIL wrap_word got=%h exp=11223355", rd); end
   endtask

   task automatic test_random();
      int nst, nerr; logic [31:0] rd, rde, last, a, d, exp; logic [3:0] s; logic w;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         acc_a(1'b1, 4'b1111, 32'h100 + 32'(i * 4), d, nst, rd, nerr, rde);
         mwrite(0, 4'b1111, 32'h100 + 32'(i * 4), d);
      end
      acc_a(1'b0, 4'b0000, 32'h100, 32'h0, nst, rd, nerr, rde);
      last = mread(0, 32'h100);
      checks++; if (rd !== last) begin failures++; $display("FAIL rnd_first got=%h exp=%h", rd, last); end
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) a = a + 32'h1000;
         s = 4'($urandom_range(0, 15));
         d = $urandom;
         acc_a(w, s, a, d, nst, rd, nerr, rde);
         if (w) begin
            checks++; if (nst !== 0 || nerr !== (legal_m(s, a) ? 0 : 1) || rde !== last) begin
               failures++;
               $display("FAIL rnd_wr i=%0d a=%h sel=%b stall=%0d err=%0d rdata=%h exp_err=%0d exp_rdata=%h",
                        i, a, s, nst, nerr, rde, legal_m(s, a) ? 0 : 1, last);
            end
            mwrite(0, s, a, d);
         end else begin
            exp = mread(0, a);
            checks++; if (nst !== 2 || rd !== exp || nerr !== 0) begin
               failures++;
               $display("FAIL rnd_rd i=%0d a=%h stall=%0d rdata=%h err=%0d exp_rdata=%h", i, a, nst, rd, nerr, exp);
            end
            last = exp;
         end
      end
   endtask

   task automatic test_nonposted();
      int nst, nerr; logic [31:0] rd;
      acc_b(1'b1, 4'b1111, 32'h30, 32'h12345678, nst, rd, nerr);
      checks++; if (nst !== 3) begin failures++; $display("FAIL np_wr_stall got=%0d exp=3", nst); end
      acc_b(1'b0, 4'b0000, 32'h30, 32'h0, nst, rd, nerr);
      checks++; if (nst !== 3) begin failures++; $display("FAIL np_rd_stall got=%0d exp=3", nst); end
      checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL np_rd_data got=%h exp=12345678", rd); end
      acc_b(1'b1, 4'b0110, 32'h30, 32'hFFFFFFFF, nst, rd, nerr);
      checks++; if (nerr !== 1 || nst !== 3) begin failures++; $display("FAIL np_ill got err=%0d stall=%0d exp err=1 stall=3", nerr, nst); end
      acc_b(1'b0, 4'b0000, 32'h30, 32'h0, nst, rd, nerr);
      checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL np_ill_unchanged got=%h exp=12345678", rd); end
   endtask

   task automatic test_reset_mid();
      int nst, nerr; logic [31:0] rd;
      en_b = 1'b1; we_b = 1'b1; sel_b = 4'hF; addr_b = 32'h30; wdata_b = 32'hCAFEF00D;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_b = 1'b1;
      @(negedge clk);
      checks++; if (stall_b !== 1'b0) begin failures++; $display("FAIL mid_rst_stall got=%b exp=0", stall_b); end
      @(posedge clk); #1;
      rst_b = 1'b0; en_b = 1'b0; we_b = 1'b0;
      @(negedge clk);
      checks++; if (rdata_b !== 32'h0) begin failures++; $display("FAIL mid_rst_rdata got=%h exp=0", rdata_b); end
      @(posedge clk); #1;
      acc_b(1'b0, 4'b0000, 32'h30, 32'h0, nst, rd, nerr);
      checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL mid_rst_discard got=%h exp=12345678", rd); end
      checks++; if (nst !== 3) begin failures++; $display("FAIL mid_rst_idle got=%0d exp=3", nst); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_posted_rw();
      test_illegal_write();
      test_back_to_back();
      test_wrap();
      test_random();
      test_nonposted();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
